// File: rtl/sudoku_board_ctrl_if.sv
// Signal bundle between the SINdoku board controller and its buttons, preload
// source and pixel renderer. The controller takes the slave side.
interface sudoku_board_ctrl_if;
    logic       btn_u;
    logic       btn_d;
    logic       btn_l;
    logic       btn_r;
    logic       btn_c;
    logic [3:0] sw_val;
    logic       load_en;
    logic [6:0] load_idx;
    logic [3:0] load_val;
    logic [3:0] rd_row;
    logic [3:0] rd_col;
    logic [3:0] rd_val;
    logic       rd_locked;
    logic [3:0] cur_row;
    logic [3:0] cur_col;
    logic       busy;
    logic       wr_ok;
    logic       wr_conflict;
    logic       wr_reject;

    modport master (
        output btn_u, btn_d, btn_l, btn_r, btn_c, sw_val,
        output load_en, load_idx, load_val, rd_row, rd_col,
        input  rd_val, rd_locked, cur_row, cur_col,
        input  busy, wr_ok, wr_conflict, wr_reject
    );

    modport slave (
        input  btn_u, btn_d, btn_l, btn_r, btn_c, sw_val,
        input  load_en, load_idx, load_val, rd_row, rd_col,
        output rd_val, rd_locked, cur_row, cur_col,
        output busy, wr_ok, wr_conflict, wr_reject
    );
endinterface

// File: rtl/sudoku_board_ctrl.sv
// 9x9 board store with lock mask, cursor control and a 9-step row/column/box
// duplicate scan that gates every cell entry before it is committed.
module sudoku_board_ctrl (
    input  logic                clk,
    input  logic                reset,
    sudoku_board_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_t;
    localparam int unsigned N_CELLS = 81;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_val  [N_CELLS];
    logic       r_lock [N_CELLS];
    logic [3:0] r_cur_row;
    logic [3:0] r_cur_col;
    logic [3:0] r_k;
    logic [3:0] r_v;
    logic       r_conflict;
    logic       r_wr_ok;
    logic       r_wr_conflict;
    logic       r_wr_reject;

    logic       w_load_we;
    logic       w_accept;
    logic       w_reject;
    logic       w_commit_we;
    logic [3:0] w_row_nxt;
    logic [3:0] w_col_nxt;
    logic       w_hit;
    logic       w_rd_in;
    logic [6:0] w_rd_idx;
    logic [6:0] w_cur_idx;
    logic [6:0] w_row_idx;
    logic [6:0] w_col_idx;
    logic [6:0] w_box_idx;
    logic [3:0] w_box_row;
    logic [3:0] w_box_col;

    function automatic logic [6:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
        return 7'(row) * 7'd9 + 7'(col);
    endfunction

    function automatic logic [1:0] div3(input logic [3:0] x);
        return (x >= 4'd6) ? 2'd2 : (x >= 4'd3) ? 2'd1 : 2'd0;
    endfunction

    // Scan step k probes (r,k), (k,c) and the k-th cell of the cursor's box.
    assign w_cur_idx = cell_idx(r_cur_row, r_cur_col);
    assign w_row_idx = cell_idx(r_cur_row, r_k);
    assign w_col_idx = cell_idx(r_k, r_cur_col);
    assign w_box_row = 4'(div3(r_cur_row)) * 4'd3 + 4'(div3(r_k));
    assign w_box_col = 4'(div3(r_cur_col)) * 4'd3 + (r_k - 4'(div3(r_k)) * 4'd3);
    assign w_box_idx = cell_idx(w_box_row, w_box_col);

    assign w_hit = (r_v != 4'd0) && (
                   ((r_k != r_cur_col) && (r_val[w_row_idx] == r_v)) ||
                   ((r_k != r_cur_row) && (r_val[w_col_idx] == r_v)) ||
                   (!((w_box_row == r_cur_row) && (w_box_col == r_cur_col)) &&
                    (r_val[w_box_idx] == r_v)));

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_load_we   = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_commit_we = 1'b0;
        w_row_nxt   = r_cur_row;
        w_col_nxt   = r_cur_col;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.load_en) begin
                    w_load_we = (bus.load_idx <= 7'd80) && (bus.load_val <= 4'd9);
                end else if (bus.btn_c) begin
                    if (r_lock[w_cur_idx] || (bus.sw_val > 4'd9)) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_SCAN;
                    end
                end else if (bus.btn_u) begin
                    w_row_nxt = (r_cur_row == 4'd0) ? 4'd8 : r_cur_row - 4'd1;
                end else if (bus.btn_d) begin
                    w_row_nxt = (r_cur_row == 4'd8) ? 4'd0 : r_cur_row + 4'd1;
                end else if (bus.btn_l) begin
                    w_col_nxt = (r_cur_col == 4'd0) ? 4'd8 : r_cur_col - 4'd1;
                end else if (bus.btn_r) begin
                    w_col_nxt = (r_cur_col == 4'd8) ? 4'd0 : r_cur_col + 4'd1;
                end
            end
            ST_SCAN: begin
                if (r_k == 4'd8) w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_commit_we = !r_conflict;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the board is plain flops rather than a RAM, so it is
            // cleared here; a reset mid-entry therefore drops the write too.
            for (int i = 0; i < N_CELLS; i++) begin
                r_val[i]  <= 4'd0;
                r_lock[i] <= 1'b0;
            end
            r_cur_row     <= 4'd0;
            r_cur_col     <= 4'd0;
            r_k           <= 4'd0;
            r_v           <= 4'd0;
            r_conflict    <= 1'b0;
            r_wr_ok       <= 1'b0;
            r_wr_conflict <= 1'b0;
            r_wr_reject   <= 1'b0;
        end else begin
            r_cur_row     <= w_row_nxt;
            r_cur_col     <= w_col_nxt;
            r_wr_reject   <= w_reject;
            r_wr_ok       <= (r_state == ST_COMMIT) && !r_conflict;
            r_wr_conflict <= (r_state == ST_COMMIT) && r_conflict;
            if (w_accept) begin
                r_v        <= bus.sw_val;
                r_conflict <= 1'b0;
                r_k        <= 4'd0;
            end else if (r_state == ST_SCAN) begin
                r_k <= (r_k == 4'd8) ? 4'd0 : r_k + 4'd1;
                if (w_hit) r_conflict <= 1'b1;
            end
            if (w_load_we) begin
                r_val[bus.load_idx]  <= bus.load_val;
                r_lock[bus.load_idx] <= (bus.load_val != 4'd0);
            end
            if (w_commit_we) r_val[w_cur_idx] <= r_v;
        end
    end

    assign w_rd_in  = (bus.rd_row <= 4'd8) && (bus.rd_col <= 4'd8);
    assign w_rd_idx = w_rd_in ? cell_idx(bus.rd_row, bus.rd_col) : 7'd0;

    assign bus.rd_val      = w_rd_in ? r_val[w_rd_idx] : 4'd0;
    assign bus.rd_locked   = w_rd_in && r_lock[w_rd_idx];
    assign bus.cur_row     = r_cur_row;
    assign bus.cur_col     = r_cur_col;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.wr_ok       = r_wr_ok;
    assign bus.wr_conflict = r_wr_conflict;
    assign bus.wr_reject   = r_wr_reject;
endmodule

// File: tb/tb_sudoku_board_ctrl.sv
// Self-checking bench for sudoku_board_ctrl: table-driven cursor moves plus
// hand sequences for entry, conflict, reject, mid-scan and reset-abort cases.
module tb_sudoku_board_ctrl;
    typedef enum logic [1:0] {EV_OK, EV_CONFLICT, EV_REJECT} ev_t;
    typedef struct {
        ev_t kind;
        int  due;
    } exp_t;
    typedef struct {
        logic       u, d, l, r;
        logic [3:0] row, col;
    } mv_vec_t;

    logic    clk = 1'b0;
    logic    reset;
    int      n_checks = 0;
    int      n_errors = 0;
    int      cyc = 0;
    exp_t    exp_q[$];
    mv_vec_t mv_tab[10];

    sudoku_board_ctrl_if bus();

    sudoku_board_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock; any pulse seen is matched against the scoreboard head.
    task automatic tick();
        int   kind;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.wr_ok || bus.wr_conflict || bus.wr_reject) begin
            kind = bus.wr_ok ? int'(EV_OK) : bus.wr_conflict ? int'(EV_CONFLICT) : int'(EV_REJECT);
            check("one pulse at a time",
                  int'(bus.wr_ok) + int'(bus.wr_conflict) + int'(bus.wr_reject), 1);
            check("pulse was expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pulse kind", kind, int'(e.kind));
                check("pulse cycle", cyc, e.due);
            end
        end
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r, input logic c);
        bus.btn_u = u;
        bus.btn_d = d;
        bus.btn_l = l;
        bus.btn_r = r;
        bus.btn_c = c;
        tick();
        bus.btn_u = 1'b0;
        bus.btn_d = 1'b0;
        bus.btn_l = 1'b0;
        bus.btn_r = 1'b0;
        bus.btn_c = 1'b0;
    endtask

    task automatic load(input logic [6:0] idx, input logic [3:0] val);
        bus.load_en  = 1'b1;
        bus.load_idx = idx;
        bus.load_val = val;
        tick();
        bus.load_en  = 1'b0;
    endtask

    task automatic set_cursor(input logic [3:0] row, input logic [3:0] col);
        for (int i = 0; i < 9 && bus.cur_row != row; i++) press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9 && bus.cur_col != col; i++) press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("cursor row reached", int'(bus.cur_row), int'(row));
        check("cursor col reached", int'(bus.cur_col), int'(col));
    endtask

    task automatic check_rd(input logic [3:0] row, input logic [3:0] col,
                            input int val, input int lock, input string name);
        bus.rd_row = row;
        bus.rd_col = col;
        #1;
        check({name, " rd_val"}, int'(bus.rd_val), val);
        check({name, " rd_locked"}, int'(bus.rd_locked), lock);
    endtask

    // Press btn_c with sw_val = val, expect the given outcome and busy length.
    task automatic entry(input logic [3:0] val, input ev_t kind, input string name);
        int   busy_cycles;
        exp_t e;
        busy_cycles = 0;
        bus.sw_val  = val;
        e.kind = kind;
        e.due  = cyc + ((kind == EV_REJECT) ? 1 : 11);
        exp_q.push_back(e);
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && bus.busy; i++) begin
            busy_cycles++;
            tick();
        end
        check({name, " busy cycles"}, busy_cycles, (kind == EV_REJECT) ? 0 : 10);
        check({name, " outcome seen"}, exp_q.size(), 0);
        tick();
        check({name, " busy after"}, int'(bus.busy), 0);
    endtask

    initial begin
        int   bad;
        exp_t e;

        mv_tab = '{
            '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd8},
            '{1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 4'd8},
            '{1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd8},
            '{1'b0, 1'b1, 1'b0, 1'b0, 4'd8, 4'd8},
            '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd8},
            '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd8},
            '{1'b1, 1'b1, 1'b0, 1'b0, 4'd8, 4'd8},
            '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd8},
            '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7}
        };

        reset        = 1'b1;
        bus.btn_u    = 1'b0;
        bus.btn_d    = 1'b0;
        bus.btn_l    = 1'b0;
        bus.btn_r    = 1'b0;
        bus.btn_c    = 1'b0;
        bus.sw_val   = 4'd0;
        bus.load_en  = 1'b0;
        bus.load_idx = 7'd0;
        bus.load_val = 4'd0;
        bus.rd_row   = 4'd0;
        bus.rd_col   = 4'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("reset cur_row", int'(bus.cur_row), 0);
        check("reset cur_col", int'(bus.cur_col), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset pulses", int'(bus.wr_ok) + int'(bus.wr_conflict) + int'(bus.wr_reject), 0);
        check_rd(4'd0, 4'd0, 0, 0, "reset cell");

        // Cursor moves with wrap-around and u>d>l>r priority.
        foreach (mv_tab[i]) begin
            press(mv_tab[i].u, mv_tab[i].d, mv_tab[i].l, mv_tab[i].r, 1'b0);
            check($sformatf("move %0d row", i), int'(bus.cur_row), int'(mv_tab[i].row));
            check($sformatf("move %0d col", i), int'(bus.cur_col), int'(mv_tab[i].col));
        end

        // Preload boundaries and out-of-range renderer lookups.
        load(7'd80, 4'd10);
        check_rd(4'd8, 4'd8, 0, 0, "load val 10 ignored");
        load(7'd80, 4'd4);
        check_rd(4'd8, 4'd8, 4, 1, "load idx 80");
        check_rd(4'd9, 4'd8, 0, 0, "rd row 9");
        check_rd(4'd8, 4'd15, 0, 0, "rd col 15");
        load(7'd80, 4'd0);
        check_rd(4'd8, 4'd8, 0, 0, "load zero unlocks");

        // Row duplicate against a locked given.
        load(7'd3, 4'd5);
        check_rd(4'd0, 4'd3, 5, 1, "given idx 3");
        set_cursor(4'd0, 4'd0);
        entry(4'd5, EV_CONFLICT, "row dup");
        check_rd(4'd0, 4'd0, 0, 0, "row dup cell");

        set_cursor(4'd4, 4'd4);
        entry(4'd7, EV_OK, "centre 7");
        check_rd(4'd4, 4'd4, 7, 0, "centre 7 cell");

        // Locked cell and invalid digit rejects.
        load(7'd40, 4'd2);
        entry(4'd3, EV_REJECT, "locked cell");
        check_rd(4'd4, 4'd4, 2, 1, "locked cell kept");
        set_cursor(4'd4, 4'd5);
        entry(4'd12, EV_REJECT, "sw_val 12");
        entry(4'd10, EV_REJECT, "sw_val 10");
        entry(4'd9, EV_OK, "sw_val 9");
        check_rd(4'd4, 4'd5, 9, 0, "sw_val 9 cell");

        // Inputs during a scan are ignored; the latched value commits.
        set_cursor(4'd5, 4'd5);
        bus.sw_val = 4'd7;
        e.kind = EV_OK;
        e.due  = cyc + 11;
        exp_q.push_back(e);
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        bus.btn_r    = 1'b1;
        bus.sw_val   = 4'd9;
        bus.load_en  = 1'b1;
        bus.load_idx = 7'd0;
        bus.load_val = 4'd9;
        tick();
        bus.btn_r   = 1'b0;
        bus.load_en = 1'b0;
        for (int i = 0; i < 20 && bus.busy; i++) tick();
        check("mid-scan outcome seen", exp_q.size(), 0);
        check("mid-scan cur_row", int'(bus.cur_row), 5);
        check("mid-scan cur_col", int'(bus.cur_col), 5);
        check_rd(4'd5, 4'd5, 7, 0, "mid-scan commit");
        check_rd(4'd0, 4'd0, 0, 0, "mid-scan load ignored");

        // Reset at edge t+5 of an entry aborts it and clears the board.
        set_cursor(4'd6, 4'd6);
        bus.sw_val = 4'd1;
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        check("busy before abort", int'(bus.busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("busy after abort", int'(bus.busy), 0);
        repeat (15) tick();
        bad = 0;
        for (int r = 0; r < 9; r++) begin
            for (int c = 0; c < 9; c++) begin
                bus.rd_row = 4'(r);
                bus.rd_col = 4'(c);
                #1;
                if (bus.rd_val != 4'd0 || bus.rd_locked) bad++;
            end
        end
        check("board cleared by reset", bad, 0);
        check("abort cur_row", int'(bus.cur_row), 0);
        check("abort cur_col", int'(bus.cur_col), 0);

        // Box, row and column duplicates, then clearing with 0.
        set_cursor(4'd1, 4'd1);
        entry(4'd3, EV_OK, "place 3");
        set_cursor(4'd2, 4'd2);
        entry(4'd3, EV_CONFLICT, "box dup");
        check_rd(4'd2, 4'd2, 0, 0, "box dup cell");
        set_cursor(4'd1, 4'd7);
        entry(4'd3, EV_CONFLICT, "row dup 2");
        set_cursor(4'd8, 4'd1);
        entry(4'd3, EV_CONFLICT, "col dup");
        set_cursor(4'd1, 4'd1);
        entry(4'd0, EV_OK, "clear cell");
        check_rd(4'd1, 4'd1, 0, 0, "cleared cell");

        repeat (3) tick();
        check("scoreboard drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sudoku_board_ctrl.md
# sudoku_board_ctrl

Board-state controller for the SINdoku display path. Holds the 9x9 cell values and given-cell lock mask, moves a selection cursor from debounced button pulses, and sequences cell entry through a 9-cycle row/column/box conflict scan before committing. The pixel renderer reads cell values and the cursor position through a combinational read port to draw numbers and the highlight.

## Interface
- No parameters; board geometry is fixed at 9x9 with 3x3 boxes.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- btn_u, btn_d, btn_l, btn_r, btn_c  in  1 each  single-cycle debounced pulses
- sw_val  in  4  value to enter: 0 clears the cell, 1-9 are digits, 10-15 are invalid
- load_en  in  1  preload strobe for the puzzle givens
- load_idx  in  7  preload cell index, row*9+col, valid range 0-80
- load_val  in  4  preload value
- rd_row, rd_col  in  4 each  renderer lookup coordinates
- rd_val  out  4  value at (rd_row, rd_col); 0 if either coordinate >8; combinational
- rd_locked  out  1  lock bit at the lookup cell; 0 if out of range; combinational
- cur_row, cur_col  out  4 each  cursor position, registered
- busy  out  1  high while an entry is scanning or committing
- wr_ok  out  1  one-cycle pulse: entry committed
- wr_conflict  out  1  one-cycle pulse: entry refused because of a duplicate
- wr_reject  out  1  one-cycle pulse: entry refused because the cell is locked or sw_val >9

## Operation
- Storage: 81x4 value register array and 81x1 lock register array.
- Reset: all values 0, all locks 0, cursor (0,0), state IDLE. busy, wr_ok, wr_conflict and wr_reject are 0.
- States: IDLE, SCAN (index k = 0..8), COMMIT.
- In IDLE, inputs are handled in this priority order:
  1. load_en: if load_idx ≤80 and load_val ≤9, write load_val and set lock = (load_val != 0). Otherwise ignore.
  2. btn_c:
     - If the cursor cell is locked or sw_val >9, pulse wr_reject and stay in IDLE.
     - Otherwise latch v = sw_val, clear the conflict flag, and go to SCAN with k = 0.
  3. Direction buttons, priority u > d > l > r; only one move per cycle.
     - u/d decrement/increment the row; l/r decrement/increment the column.
     - Wrap-around: 0 -1 → 8, and 8 +1 → 0.
- SCAN step k, with cursor (r,c) and box origin (br,bc) = (3*(r/3), 3*(c/3)). Set the conflict flag if v != 0 and any of these cells holds v:
  - (r,k) when k != c
  - (k,c) when k != r
  - (br+k/3, bc+k%3) when that cell is not (r,c)
  - After k = 8, go to COMMIT.
- COMMIT:
  - Flag clear: write v to (r,c) and pulse wr_ok.
  - Flag set: leave the board unchanged and pulse wr_conflict.
  - Then return to IDLE.
- v = 0 (clear) never conflicts and always commits.
- While busy, these are ignored and not queued: buttons, load_en, and sw_val changes (v is already latched). The cursor is frozen.
- The lock bit is never changed by entry; only load and reset change it.
- Reset asserted in SCAN or COMMIT aborts the entry: no write and no pulse.

## Timing
- A btn_c accepted at edge t:
  - busy is 1 after edge t through edge t+10.
  - Scan steps k = 0..8 are evaluated at edges t+1..t+9.
  - At edge t+10, the board write and the wr_ok/wr_conflict pulse take effect, and busy returns to 0.
  - The pulse is high for exactly the cycle after edge t+10.
- The next btn_c is accepted at edge t+11 or later.
- wr_reject is registered at the sampling edge t and lasts one cycle. busy stays 0.
- Cursor moves and loads take effect at the sampling edge; cur_row/cur_col update one cycle after the pulse.
- rd_val and rd_locked have zero latency and reflect the board after the most recent edge, including a commit at t+10.
- All pulse outputs deassert the cycle after they are asserted.

## Test plan
- Reset, then btn_l once → cur_col = 8, cur_row = 0. Then btn_u → cur_row = 8. Press btn_u and btn_r in the same cycle → only the row changes.
- Preload idx 3 = 5 (locked). Cursor (0,0), sw_val = 5, btn_c → busy for 10 cycles, then wr_conflict; rd_val(0,0) = 0.
- Cursor (4,4), sw_val = 7, no 7 in row 4, column 4 or the centre box, btn_c at edge t → wr_ok after edge t+10; rd_val(4,4) = 7; busy = 0 at t+11.
- Preload idx 40 = 2 (locked). Cursor (4,4), btn_c → wr_reject the next cycle, busy never rises. Also sw_val = 12 on an unlocked cell → wr_reject.
- Mid-scan, pulse btn_r and change sw_val to 9 → cursor unchanged, value 7 committed. Assert reset at edge t+5 → board all 0, no pulses.
- Place 3 at (1,1), then enter 3 at (2,2) (same box) → wr_conflict. Enter 0 at (1,1) → wr_ok; rd_val(1,1) = 0.
